mul_sequencer: RTL

- Multi-cycle unsigned shift-and-add multiplier that borrows the single-cycle `Executs32` ALU rather than adding a dedicated multiplier.
- Drives `Executs32`'s operand and control inputs through an add/sll sequence and captures `ALU_Result` each cycle.
- Returns the low 32 bits of the product with a `done` pulse.
- Sits beside the decoder: the integrator muxes these ALU drive outputs onto `Executs32` while `busy` is high.

---
 rtl/mul_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle unsigned shift-and-add multiplier that borrows the shared
// Executs32 ALU instead of instantiating a dedicated multiplier.
//
// Each multiplier bit takes two cycles:
//   EVAL  - ALU adds acc + mcand; the sum is kept only if the current multiplier bit is set.
//   SHIFT - ALU shifts mcand left by one; the multiplier shifts right and the bit count advances.
// DONE pulses `done` for one cycle with the low 32 bits of the product on `product`.
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   start                  request, sampled only while idle
//   multiplicand/multiplier operands, latched on accept
//   busy, done, product    status and result (product held until the next accept)
//   alu_*                  drives for the Executs32 inputs, muxed in by the integrator while busy
//   alu_result             Executs32 ALU_Result, combinational in the same cycle
//
// Build option: MULSEQ_EARLY_EXIT_EN ends the sequence once no set multiplier bits remain,
// giving a latency of 2*k+1 cycles (k = highest set multiplier bit index + 1, minimum 1).
module mul_sequencer #(
  parameter int unsigned ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [31:0] alu_read_data_1,
  output logic [31:0] alu_read_data_2,
  output logic [5:0]  alu_function_opcode,
  output logic [5:0]  alu_exe_opcode,
  output logic [1:0]  alu_aluop,
  output logic [4:0]  alu_shamt,
  output logic        alu_sftmd,
  output logic        alu_alusrc,
  output logic        alu_i_format,
  input  logic [31:0] alu_result
);

  typedef enum logic [1:0] {StIdle, StEval, StShift, StDone} state_e;

  localparam logic [5:0] LastCnt = 6'(ITER - 1);

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] product_q, product_d;
  logic        last_bit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Final SHIFT of the sequence.
`ifdef MULSEQ_EARLY_EXIT_EN
  assign last_bit = (cnt_q == LastCnt) || (mplier_q[31:1] == 31'd0);
`else
  assign last_bit = (cnt_q == LastCnt);
`endif

  always_comb begin
    state_d             = state_q;
    acc_d               = acc_q;
    mcand_d             = mcand_q;
    mplier_d            = mplier_q;
    cnt_d               = cnt_q;
    product_d           = product_q;
    alu_read_data_1     = '0;
    alu_read_data_2     = '0;
    alu_function_opcode = '0;
    alu_exe_opcode      = '0;
    alu_aluop           = '0;
    alu_shamt           = '0;
    alu_sftmd           = 1'b0;
    alu_alusrc          = 1'b0;
    alu_i_format        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = multiplicand;
          mplier_d = multiplier;
          cnt_d    = '0;
          state_d  = StEval;
        end
      end
      StEval: begin
        // R-type add: acc + mcand
        alu_function_opcode = 6'b100000;
        alu_aluop           = 2'b10;
        alu_read_data_1     = acc_q;
        alu_read_data_2     = mcand_q;
        if (mplier_q[0]) acc_d = alu_result;
        state_d = StShift;
      end
      StShift: begin
        // R-type sll by 1 on mcand
        alu_aluop       = 2'b10;
        alu_sftmd       = 1'b1;
        alu_shamt       = 5'd1;
        alu_read_data_2 = mcand_q;
        mcand_d         = alu_result;
        mplier_d        = mplier_q >> 1;
        cnt_d           = cnt_q + 6'd1;
        if (last_bit) begin
          // acc is final here: SHIFT never modifies it.
          product_d = acc_q;
          state_d   = StDone;
        end else begin
          state_d = StEval;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule
